// File: rtl/lsu_subword_ctrl.sv
// Load/store unit turning byte/half/word CPU accesses into whole-word
// DMEM cycles, with read-modify-write for sub-word stores.
module lsu_subword_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              dm_cs,
   output logic              dm_r,
   output logic              dm_w,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_sext;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;
   logic [DATA_W-1:0] r_word;

   logic              w_acc;
   logic              w_mis;
   logic [4:0]        w_shamt;
   logic [DATA_W-1:0] w_shw;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_ld;
   logic [DATA_W-1:0] w_mask;
   logic [DATA_W-1:0] w_rep;
   logic [DATA_W-1:0] w_merge;

   assign w_acc = (r_state == S_IDLE) && req;
   assign w_mis = (size == 2'b11)
                | ((size == 2'b01) && addr[0])
                | ((size == 2'b10) && (addr[1:0] != 2'b00));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_sext  <= 1'b0;
         r_wdata <= '0;
         r_err   <= 1'b0;
         r_word  <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_addr  <= addr;
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_wdata <= wdata;
            r_err   <= w_mis;
         end
         if (r_state == S_RD) r_word <= dm_rdata;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (req) begin
               if (w_mis)                      w_next = S_RESP;
               else if (!we || size != 2'b10)  w_next = S_RD;
               else                            w_next = S_WR;
            end
         end
         S_RD:   w_next = r_we ? S_WR : S_RESP;
         S_WR:   w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // little-endian lane selection from the latched address
   assign w_shamt = {r_addr[1:0], 3'b000};
   assign w_shw   = r_word >> w_shamt;
   assign w_byte  = w_shw[7:0];
   assign w_half  = r_addr[1] ? r_word[31:16] : r_word[15:0];

   always_comb begin
      w_ld   = r_word;
      w_mask = '1;
      w_rep  = r_wdata;
      unique case (r_size)
         2'b00: begin
            w_ld   = {{24{r_sext & w_byte[7]}}, w_byte};
            w_mask = 32'h0000_00FF << w_shamt;
            w_rep  = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_ld   = {{16{r_sext & w_half[15]}}, w_half};
            w_mask = r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            w_rep  = {2{r_wdata[15:0]}};
         end
         default: begin
            w_ld   = r_word;
            w_mask = '1;
            w_rep  = r_wdata;
         end
      endcase
   end

   assign w_merge = (r_word & ~w_mask) | (w_rep & w_mask);

   always_comb begin
      rdata    = '0;
      done     = 1'b0;
      err      = 1'b0;
      busy     = (r_state != S_IDLE);
      dm_cs    = 1'b0;
      dm_r     = 1'b0;
      dm_w     = 1'b0;
      dm_wdata = '0;
      unique case (r_state)
         S_RD: begin
            dm_cs = 1'b1;
            dm_r  = 1'b1;
         end
         S_WR: begin
            dm_cs    = 1'b1;
            dm_w     = 1'b1;
            dm_wdata = w_merge;
         end
         S_RESP: begin
            done = 1'b1;
            err  = r_err;
            if (!r_we && !r_err) rdata = w_ld;
         end
         default: ;
      endcase
   end

   assign dm_addr = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed + random bench for lsu_subword_ctrl against a byte-array
// memory model with spec-level latency and extension rules.
module tb_lsu_subword_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic        busy;
   logic        dm_cs;
   logic        dm_r;
   logic        dm_w;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   logic [7:0]  refb [256];

   always #5 clk = ~clk;

   lsu_subword_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .dm_cs    (dm_cs),
      .dm_r     (dm_r),
      .dm_w     (dm_w),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata)
   );

   assign dm_rdata = mem[dm_addr[7:2]];

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (dm_cs && dm_w) mem[dm_addr[7:2]] <= dm_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++)
         v = v | (32'(refb[{a[7:2], 2'b00} + 8'(i)]) << (8 * i));
      return v;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = a[7:2];
      pl_val = v;
      for (int i = 0; i < 4; i++)
         refb[{a[7:2], 2'b00} + 8'(i)] = v[8*i +: 8];
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic access(input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input bit tog,
                         output logic [31:0] o_rd,
                         output logic [31:0] o_wd);
      bit          e_err;
      int          n;
      int          lat;
      logic [31:0] e_rd;
      bit          saw_r = 0;
      bit          saw_w = 0;
      bit          saw_cs = 0;
      bit          got = 0;
      e_err = (sz == 2'b11) || (sz == 2'b01 && a[0])
           || (sz == 2'b10 && a[1:0] != 2'b00);
      n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      lat = e_err ? 1 : (!w || sz == 2'b10) ? 2 : 3;
      e_rd = '0;
      if (!e_err && !w) begin
         for (int i = 0; i < n; i++)
            e_rd = e_rd | (32'(refb[8'(a) + 8'(i)]) << (8 * i));
         if (sx && n < 4 && e_rd[8*n-1])
            e_rd = e_rd | ~((32'd1 << (8 * n)) - 32'd1);
      end
      o_rd = '0;
      o_wd = '0;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sign_ext = sx;
      addr = a; wdata = wd;
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("busy_in_op", {31'b0, busy}, 32'd1);
         if (dm_cs) begin
            saw_cs = 1;
            chk("dm_addr", dm_addr, {a[31:2], 2'b00});
         end
         if (dm_r) saw_r = 1;
         if (dm_w) begin
            saw_w = 1;
            o_wd = dm_wdata;
         end
         if (done) begin
            chk("latency", 32'(c), 32'(lat));
            chk("err", {31'b0, err}, {31'b0, e_err});
            chk("rdata", rdata, e_rd);
            o_rd = rdata;
            got = 1;
            req = 1'b0;
            break;
         end
         if (tog) req = ~req;
      end
      if (!got) begin
         tests++;
         fails++;
         $error("FAIL timeout waiting for done addr=%h", a);
         req = 1'b0;
      end
      chk("saw_cs", {31'b0, saw_cs}, {31'b0, !e_err});
      chk("saw_r", {31'b0, saw_r}, {31'b0, !e_err && (!w || sz != 2'b10)});
      chk("saw_w", {31'b0, saw_w}, {31'b0, !e_err && w});
      if (w && !e_err)
         for (int i = 0; i < n; i++) refb[8'(a) + 8'(i)] = wd[8*i +: 8];
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("mem_word", mem[a[7:2]], ref_word(a));
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] wdo;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00;
      sign_ext = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 256; i++) refb[i] = 8'h00;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_flags", {26'b0, done, err, busy, dm_cs, dm_r, dm_w}, 32'd0);
      chk("rst_wdata", dm_wdata, 32'd0);
      chk("rst_addr", dm_addr, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_cs", {31'b0, dm_cs}, 32'd0);
      chk("idle_busy0", {31'b0, busy}, 32'd0);

      for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);

      preload(32'h40, 32'h11223344);
      access(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AB, 0, rd, wdo);
      chk("sb_wdata", wdo, 32'h1122AB44);

      preload(32'h40, 32'h80FF7F01);
      access(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, 0, rd, wdo);
      chk("lb", rd, 32'hFFFFFFFF);
      access(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 0, rd, wdo);
      chk("lbu", rd, 32'h000000FF);
      access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 0, rd, wdo);
      chk("lh", rd, 32'hFFFF80FF);
      access(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 0, rd, wdo);
      chk("lw", rd, 32'h80FF7F01);

      access(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, 0, rd, wdo);
      chk("sw_wdata", wdo, 32'hDEADBEEF);
      access(1'b1, 2'b01, 1'b0, 32'h46, 32'h00001234, 0, rd, wdo);
      chk("sh_mem", mem[6'h11], 32'h1234BEEF);

      access(1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 0, rd, wdo);
      access(1'b1, 2'b10, 1'b0, 32'h42, 32'h5, 0, rd, wdo);
      access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, rd, wdo);
      access(1'b1, 2'b11, 1'b0, 32'h44, 32'h7, 0, rd, wdo);
      chk("err_mem", mem[6'h11], 32'h1234BEEF);

      access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1, rd, wdo);
      chk("tog_rd", rd, 32'h1234BEEF);
      access(1'b1, 2'b00, 1'b0, 32'h45, 32'h77, 1, rd, wdo);

      preload(32'h40, 32'h55667788);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0;
      addr = 32'h40; wdata = 32'hCC;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rd", {31'b0, dm_r}, 32'd1);
      rst_n = 1'b0;
      req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_no_w", {30'b0, dm_w, done}, 32'd0);
         if (c == 1) rst_n = 1'b1;
      end
      chk("mid_mem", mem[6'h10], 32'h55667788);
      chk("mid_busy", {31'b0, busy}, 32'd0);

      for (int k = 0; k < 60; k++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 255));
         access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                bit'($urandom_range(0, 3) == 0), rd, wdo);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
- Load/store unit between the CPU datapath and the word-addressed data memory (DMEM).
- The memory only reads and writes whole 32-bit words, so this block turns byte, halfword and word loads/stores into memory cycles.
- Sub-word stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended before being returned to the CPU.

Parameters:
- ADDR_W, 32, width of the CPU and memory byte address.
- DATA_W, 32, data word width; fixed at 32, since lane logic assumes 4 bytes.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  in  1  CPU access request; must be held, with all request fields stable, until done.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, extended; valid while done=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned or reserved-size access; valid with done.
- busy  out  1  high whenever the FSM is not IDLE.
- dm_cs  out  1  memory chip select.
- dm_r  out  1  memory read strobe.
- dm_w  out  1  memory write strobe.
- dm_addr  out  32  word-aligned byte address: {addr_q[31:2], 2'b00}.
- dm_wdata  out  32  word written to memory.
- dm_rdata  in  32  memory read data, combinational from dm_addr.

Behaviour:
- Reset: synchronous; rst_n=0 at a clock edge forces state IDLE and sets rdata, done, err, busy, dm_cs, dm_r, dm_w, dm_wdata and the internal latches to 0.
- Reset mid-operation: aborts the access; no dm_w in the cycle after the reset edge; no done pulse.
- Accept: a request is accepted only in IDLE with req=1; addr, we, size, sign_ext and wdata are latched at that edge.
  - req is ignored in all other states, including the RESP cycle.
  - Minimum spacing between accepts is therefore RESP+1.
- Lane mapping is little-endian:
  - byte lane k = addr[1:0] occupies bits [8k+7:8k];
  - half lane = addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
- Alignment check, evaluated at accept:
  - err if size=11;
  - err if size=01 and addr[0]=1;
  - err if size=10 and addr[1:0]!=0.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RESP when the accepted access is an error; err=1 in RESP; no memory strobes at all.
  - IDLE -> RD for a load, or for a byte/half store.
  - IDLE -> WR for a word store.
  - RD: dm_cs=1, dm_r=1; dm_rdata is captured at the end of the cycle. Next state is RESP for a load, WR for a store.
  - WR: dm_cs=1, dm_w=1. dm_wdata is the captured word with the addressed lanes replaced by wdata_q[7:0] or wdata_q[15:0], or is wdata_q for a word store. Next state is RESP.
  - RESP: done=1 for exactly one cycle. rdata holds the extracted lane, extended per sign_ext_q; rdata=0 for stores and errors. Next state is IDLE.
- Strobes are decoded from state (Moore); dm_addr is stable from RD/WR entry through RESP.
- Latency, counted from the accept edge (cycle 0), with done high in the stated cycle:
  - load: 2;
  - word store: 2;
  - byte/half store: 3;
  - error: 1.
- busy=1 from cycle 1 up to and including the RESP cycle.
- Unaddressed bytes of the memory word must be preserved exactly on every sub-word store.
- sign_ext is ignored for word loads and for stores.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> all outputs 0; no dm_cs while req=0.
- Byte store:
  - preload mem[0x40]=0x11223344;
  - sb addr=0x41, wdata=0xAB -> RD at cycle 1, WR at cycle 2 with dm_wdata=0x1122AB44, done at cycle 3, err=0.
- Loads from mem[0x40]=0x80FF7F01:
  - lb addr=0x42, sign_ext=1 -> rdata=0xFFFFFFFF;
  - lbu same address -> rdata=0x000000FF;
  - lh addr=0x42, sign_ext=1 -> rdata=0xFFFF80FF;
  - lw addr=0x40 -> rdata=0x80FF7F01.
  - Each load has done at cycle 2.
- Word and half stores:
  - sw addr=0x44, wdata=0xDEADBEEF -> no dm_r, dm_w at cycle 1, done at cycle 2;
  - then sh addr=0x46, wdata=0x1234 -> mem[0x44]=0x1234BEEF.
- Misalignment:
  - lh addr=0x43 -> done and err at cycle 1, no dm_cs;
  - sw addr=0x42 and size=11 -> same response.
- Reset mid-op: assert rst_n=0 in the RD cycle of sb addr=0x40 -> dm_w never asserted; mem unchanged; no done pulse.
- Busy hold: toggle req during busy -> no second accept.
